// File: rtl/tp_ntt_cfg_seq.sv
// Command sequencer for one TP-NTT stage: sequences modulus/twiddle loads and
// the run-mode input gating plus the output-valid strobe that tracks stage latency.
module tp_ntt_cfg_seq #(
  parameter int unsigned N          = 128,
  parameter int unsigned TP         = 8,
  parameter int unsigned LOGQ       = 32,
  parameter int unsigned ITER_PARTS = 3,
  parameter int unsigned PIPE_LAT   = 30,
  parameter int unsigned Q_HOLD     = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [1:0]               i_cmd_op,
  input  logic [LOGQ-1:0]          i_cmd_q,
  input  logic                     i_tw_valid,
  output logic                     o_tw_ready,
  input  logic [(TP-1)*LOGQ-1:0]   i_tw_data,
  input  logic                     i_din_valid,
  input  logic [TP*LOGQ-1:0]       i_din,
  output logic [1:0]               o_op_type_out,
  output logic [LOGQ-1:0]          o_q_out,
  output logic [(TP-1)*LOGQ-1:0]   o_twiddle_out,
  output logic [TP*LOGQ-1:0]       o_ntt_in,
  output logic                     o_start_out,
  output logic                     o_dout_valid,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err_underrun
);

  localparam int unsigned TW_TOTAL = ITER_PARTS * (N / TP);
  localparam int unsigned CntMax   = (TW_TOTAL > Q_HOLD) ? TW_TOTAL : Q_HOLD;
  localparam int unsigned CntW     = $clog2(CntMax) + 1;
  localparam int unsigned TwW      = (TP - 1) * LOGQ;
  localparam int unsigned DinW     = TP * LOGQ;

  typedef enum logic [2:0] {S_IDLE, S_Q, S_TW_PRIME, S_TW, S_RUN} state_e;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [1:0]          r_op_type, w_op_type_d;
  logic [LOGQ-1:0]     r_q, w_q_d;
  logic [TwW-1:0]      r_twiddle, w_twiddle_d;
  logic [DinW-1:0]     r_ntt_in, w_ntt_in_d;
  logic                r_done, w_done_d;
  logic                r_err, w_err_d;
  logic [PIPE_LAT-1:0] r_pipe;
  logic                w_run_beat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op_type <= '0;
      r_q       <= '0;
      r_twiddle <= '0;
      r_ntt_in  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_pipe    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_op_type <= w_op_type_d;
      r_q       <= w_q_d;
      r_twiddle <= w_twiddle_d;
      r_ntt_in  <= w_ntt_in_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
      r_pipe    <= {r_pipe[PIPE_LAT-2:0], w_run_beat};
    end
  end

  // OP_TYPE defaults to 0 each cycle, so any nonzero code lasts exactly one cycle.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_op_type_d = 2'd0;
    w_q_d       = r_q;
    w_twiddle_d = '0;
    w_ntt_in_d  = '0;
    w_done_d    = 1'b0;
    w_err_d     = r_err;
    w_run_beat  = 1'b0;
    o_cmd_ready = 1'b0;
    o_tw_ready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        w_cnt_d     = '0;
        if (i_cmd_valid) begin
          case (i_cmd_op)
            2'd0: begin
              w_q_d       = i_cmd_q;
              w_op_type_d = 2'd3;
              w_state_d   = S_Q;
            end
            2'd1: w_state_d = S_TW_PRIME;
            2'd2: begin
              w_op_type_d = 2'd2;
              w_state_d   = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_Q: begin
        if (r_cnt == CntW'(Q_HOLD - 1)) begin
          w_done_d  = 1'b1;
          w_cnt_d   = '0;
          w_state_d = S_IDLE;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      S_TW_PRIME: begin
        if (i_tw_valid) begin
          w_op_type_d = 2'd1;
          w_cnt_d     = '0;
          w_state_d   = S_TW;
        end
      end
      S_TW: begin
        // The stage counts words unconditionally, so a missing word becomes a zero slot.
        o_tw_ready = 1'b1;
        if (i_tw_valid) begin
          w_twiddle_d = i_tw_data;
        end else begin
          w_err_d = 1'b1;
        end
        if (r_cnt == CntW'(TW_TOTAL - 1)) begin
          w_done_d  = 1'b1;
          w_cnt_d   = '0;
          w_state_d = S_IDLE;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      S_RUN: begin
        w_run_beat = i_din_valid;
        if (i_din_valid) begin
          w_ntt_in_d = i_din;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  assign o_op_type_out  = r_op_type;
  assign o_q_out        = r_q;
  assign o_twiddle_out  = r_twiddle;
  assign o_ntt_in       = r_ntt_in;
  assign o_start_out    = 1'b0;
  assign o_dout_valid   = r_pipe[PIPE_LAT-1];
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_err_underrun = r_err;

endmodule

// File: tb/tb_tp_ntt_cfg_seq.sv
// Randomized bench for tp_ntt_cfg_seq; expected traces are computed per command
// from the command semantics (word order, slot counts, fixed latencies).
module tb_tp_ntt_cfg_seq;
  localparam int unsigned N          = 128;
  localparam int unsigned TP         = 8;
  localparam int unsigned LOGQ       = 32;
  localparam int unsigned ITER_PARTS = 3;
  localparam int unsigned PIPE_LAT   = 30;
  localparam int unsigned Q_HOLD     = 3;
  localparam int unsigned TW_TOTAL   = ITER_PARTS * (N / TP);
  localparam int unsigned TWW        = (TP - 1) * LOGQ;
  localparam int unsigned DW         = TP * LOGQ;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [LOGQ-1:0] cmd_q;
  logic            tw_valid;
  logic            tw_ready;
  logic [TWW-1:0]  tw_data;
  logic            din_valid;
  logic [DW-1:0]   din;
  logic [1:0]      op_type;
  logic [LOGQ-1:0] q_out;
  logic [TWW-1:0]  twiddle;
  logic [DW-1:0]   ntt_in;
  logic            start_out;
  logic            dout_valid;
  logic            busy;
  logic            done;
  logic            err_underrun;

  int n_chk = 0;
  int n_err = 0;
  logic            exp_err;
  logic [LOGQ-1:0] exp_q;

  tp_ntt_cfg_seq #(
    .N(N), .TP(TP), .LOGQ(LOGQ), .ITER_PARTS(ITER_PARTS), .PIPE_LAT(PIPE_LAT), .Q_HOLD(Q_HOLD)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_q       (cmd_q),
    .i_tw_valid    (tw_valid),
    .o_tw_ready    (tw_ready),
    .i_tw_data     (tw_data),
    .i_din_valid   (din_valid),
    .i_din         (din),
    .o_op_type_out (op_type),
    .o_q_out       (q_out),
    .o_twiddle_out (twiddle),
    .o_ntt_in      (ntt_in),
    .o_start_out   (start_out),
    .o_dout_valid  (dout_valid),
    .o_busy        (busy),
    .o_done        (done),
    .o_err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_q = '0;
    tw_valid  = 1'b0; tw_data = '0;
    din_valid = 1'b0; din = '0;
  endtask

  function automatic logic [TWW-1:0] rand_tw();
    logic [TWW-1:0] w;
    for (int i = 0; i < TP - 1; i++) w[i*LOGQ +: LOGQ] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] rand_din();
    logic [DW-1:0] w;
    for (int i = 0; i < TP; i++) w[i*LOGQ +: LOGQ] = $urandom;
    return w;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, ".op_type"}, op_type, 0);
    chk({tag, ".q_out"}, q_out, 0);
    chk({tag, ".twiddle"}, twiddle, 0);
    chk({tag, ".ntt_in"}, ntt_in, 0);
    chk({tag, ".start"}, start_out, 0);
    chk({tag, ".dout_valid"}, dout_valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err_underrun, 0);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    chk({tag, ".tw_ready"}, tw_ready, 0);
  endtask

  task automatic do_reset(input string tag);
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_err = 1'b0;
    exp_q   = '0;
    check_reset(tag);
  endtask

  task automatic idle_op3();
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_q = $urandom;
    step();
    cmd_valid = 1'b0;
    chk("op3.busy", busy, 0);
    chk("op3.op_type", op_type, 0);
    chk("op3.done", done, 0);
    chk("op3.cmd_ready", cmd_ready, 1);
    chk("op3.q_out", q_out, exp_q);
    step();
    chk("op3.busy2", busy, 0);
  endtask

  task automatic load_q(input logic [LOGQ-1:0] q);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_q = q;
    step();
    exp_q = q;
    for (int k = 1; k <= int'(Q_HOLD) + 1; k++) begin
      chk("ldq.op_type", op_type, (k == 1) ? 2'd3 : 2'd0);
      chk("ldq.q_out", q_out, exp_q);
      chk("ldq.done", done, (k == int'(Q_HOLD) + 1));
      chk("ldq.busy", busy, (k <= int'(Q_HOLD)));
      chk("ldq.cmd_ready", cmd_ready, (k > int'(Q_HOLD)));
      // Host keeps pushing commands while busy; none may be taken.
      cmd_valid = (k <= int'(Q_HOLD));
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_q     = $urandom;
      if (k <= int'(Q_HOLD)) step();
    end
    step();
    chk("ldq.done_pulse", done, 0);
    chk("ldq.q_hold", q_out, exp_q);
    chk("ldq.idle_op", op_type, 0);
  endtask

  // mode 0: words 1..TW_TOTAL contiguous; 1: gap at words 20,21; 2: random words and gaps.
  task automatic load_tw(input int mode, input int abort_at);
    logic [TWW-1:0] words [TW_TOTAL];
    logic [TWW-1:0] exp_tw [TW_TOTAL];
    bit             pat [TW_TOTAL];
    bit             gap;
    int             nv;
    int             vi;
    int             d;
    gap = 1'b0;
    nv  = 0;
    for (int j = 0; j < int'(TW_TOTAL); j++) begin
      words[j] = (mode == 2) ? rand_tw() : TWW'(j + 1);
      pat[j]   = (mode == 0) ? 1'b1 :
                 (mode == 1) ? !(j == 19 || j == 20) : ($urandom_range(0, 7) != 0);
    end
    for (int j = 0; j < int'(TW_TOTAL); j++) begin
      if (pat[j]) begin
        exp_tw[j] = words[nv];
        nv++;
      end else begin
        exp_tw[j] = '0;
        gap = 1'b1;
      end
    end
    cmd_valid = 1'b1; cmd_op = 2'd1;
    step();
    cmd_valid = 1'b0;
    d = int'($urandom_range(0, 3));
    for (int p = 0; p < d; p++) begin
      chk("tw.prime_ready", tw_ready, 0);
      chk("tw.prime_busy", busy, 1);
      tw_valid = 1'b0; tw_data = rand_tw();
      step();
    end
    chk("tw.prime_ready", tw_ready, 0);
    chk("tw.prime_op", op_type, 0);
    tw_valid = 1'b1; tw_data = words[0];
    step();
    chk("tw.op_type1", op_type, 2'd1);
    vi = 0;
    for (int j = 0; j < int'(TW_TOTAL); j++) begin
      if (j == abort_at) begin
        do_reset("tw.abort");
        return;
      end
      chk("tw.ready", tw_ready, 1);
      tw_valid = pat[j];
      tw_data  = pat[j] ? words[vi] : rand_tw();
      if (pat[j]) vi++;
      step();
      chk("tw.word", twiddle, exp_tw[j]);
      chk("tw.done", done, (j == int'(TW_TOTAL) - 1));
      chk("tw.op_type0", op_type, 0);
    end
    tw_valid = 1'b1; tw_data = rand_tw();
    exp_err = exp_err | gap;
    chk("tw.err", err_underrun, exp_err);
    chk("tw.busy", busy, 0);
    chk("tw.cmd_ready", cmd_ready, 1);
    chk("tw.tw_ready_idle", tw_ready, 0);
    step();
    tw_valid = 1'b0;
    chk("tw.tail_zero", twiddle, 0);
    chk("tw.done_pulse", done, 0);
    chk("tw.err_sticky", err_underrun, exp_err);
  endtask

  // mode 0: 16 contiguous beats starting at cycle 2; 1: random beats in the first 40 cycles.
  task automatic run_cmd(input int mode, input int abort_at);
    bit            dvp [100];
    logic [DW-1:0] dat [100];
    for (int t = 0; t < 100; t++) begin
      dvp[t] = (mode == 0) ? (t >= 2 && t < 18) : (t < 40 && $urandom_range(0, 1) == 1);
      dat[t] = rand_din();
    end
    // A beat offered in the accepting cycle precedes run mode and must be dropped.
    cmd_valid = 1'b1; cmd_op = 2'd2; din_valid = 1'b1; din = rand_din();
    step();
    for (int t = 0; t < 100; t++) begin
      chk("run.op_type", op_type, (t == 0) ? 2'd2 : 2'd0);
      chk("run.cmd_ready", cmd_ready, 0);
      chk("run.busy", busy, 1);
      chk("run.ntt_in", ntt_in, (t > 0 && dvp[t-1]) ? dat[t-1] : '0);
      chk("run.dout_valid", dout_valid, (t >= int'(PIPE_LAT)) && dvp[t-int'(PIPE_LAT)]);
      if (t == abort_at) begin
        do_reset("run.abort");
        for (int k = 0; k < int'(PIPE_LAT) + 5; k++) begin
          step();
          chk("run.post_dv", dout_valid, 0);
          chk("run.post_busy", busy, 0);
        end
        return;
      end
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 2'($urandom_range(0, 3));
      din_valid = dvp[t];
      din       = dat[t];
      step();
    end
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_err = 1'b0;
    exp_q   = '0;
    check_reset("por");
    idle_op3();
    load_q(32'h0FFF_F001);
    load_q($urandom);
    idle_op3();
    load_tw(0, -1);
    load_tw(1, -1);
    load_tw(2, -1);
    load_tw(2, 10);
    load_q($urandom);
    load_tw(2, -1);
    run_cmd(0, 50);
    load_q($urandom);
    load_tw(0, -1);
    run_cmd(1, 55);
    idle_op3();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
